// File: rtl/sar_result_reader_if.sv
// Downstream valid/ready stream carrying finished SAR result words.
interface sar_result_reader_if #(
    parameter int WIDTH = 8
) ();
    logic             m_valid;
    logic             m_ready;
    logic [WIDTH-1:0] m_data;

    modport master (output m_valid, output m_data, input m_ready);
    modport slave  (input m_valid, input m_data, output m_ready);
endinterface

// File: rtl/sar_result_reader.sv
// Captures SAR end-of-conversion results, optionally averages 2^AVG_LOG2 of them,
// and queues the words in a small FIFO with overflow accounting.
module sar_result_reader #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 4,
    parameter int AVG_LOG2 = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     sar_eoc,
    input  logic [WIDTH-1:0]         sar_code,
    sar_result_reader_if.master      dn,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     ovf,
    input  logic                     clr_ovf,
    output logic [7:0]               drop_cnt
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH+2:0] acc;
    logic [2:0]       cnt;
    logic [WIDTH+2:0] sum;
    logic             sample;
    logic             push;
    logic [WIDTH-1:0] push_word;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             full;
    logic             empty;
    logic             pop;
    logic             do_write;
    logic             drop;

    // A word is produced when the sample just taken completes a group of 2^AVG_LOG2.
    always_comb begin
        sample    = en & sar_eoc;
        sum       = acc + (WIDTH+3)'(sar_code);
        push      = sample && (({1'b0, cnt} + 4'd1) == 4'(2 ** AVG_LOG2));
        push_word = WIDTH'(sum >> AVG_LOG2);
    end

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            acc <= '0;
            cnt <= '0;
        end else if (sample) begin
            if (push) begin
                acc <= '0;
                cnt <= '0;
            end else begin
                acc <= sum;
                cnt <= cnt + 3'd1;
            end
        end
    end

    // A full FIFO still accepts a push when the head leaves on the same edge.
    always_comb begin
        level      = wr_ptr - rd_ptr;
        full       = (level == (AW+1)'(DEPTH));
        empty      = (level == '0);
        pop        = !empty && dn.m_ready;
        do_write   = push && (!full || pop);
        drop       = push && full && !pop;
        dn.m_valid = !empty;
        dn.m_data  = mem[rd_ptr[AW-1:0]];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_write) begin
                mem[wr_ptr[AW-1:0]] <= push_word;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // A drop on the same edge as a clear restarts the count at one.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf      <= 1'b0;
            drop_cnt <= '0;
        end else if (drop) begin
            ovf <= 1'b1;
            if (clr_ovf)                drop_cnt <= 8'd1;
            else if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
        end else if (clr_ovf) begin
            ovf      <= 1'b0;
            drop_cnt <= '0;
        end
    end
endmodule

// File: tb/tb_sar_result_reader.sv
// Drives two readers (no averaging and 4-way averaging) with shared stimulus and
// checks both against a queue-based reference model every cycle.
module tb_sar_result_reader;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst, en, sar_eoc, clr_ovf, m_ready;
    logic [7:0] sar_code;

    logic [2:0] level0, level2;
    logic       ovf0, ovf2;
    logic [7:0] drop0, drop2;

    int checks = 0;
    int errors = 0;

    sar_result_reader_if #(.WIDTH(8)) bus0 ();
    sar_result_reader_if #(.WIDTH(8)) bus2 ();

    assign bus0.m_ready = m_ready;
    assign bus2.m_ready = m_ready;

    sar_result_reader #(.WIDTH(8), .DEPTH(DEPTH), .AVG_LOG2(0)) dut0 (
        .clk(clk), .rst(rst), .en(en), .sar_eoc(sar_eoc), .sar_code(sar_code),
        .dn(bus0), .level(level0), .ovf(ovf0), .clr_ovf(clr_ovf), .drop_cnt(drop0)
    );

    sar_result_reader #(.WIDTH(8), .DEPTH(DEPTH), .AVG_LOG2(2)) dut2 (
        .clk(clk), .rst(rst), .en(en), .sar_eoc(sar_eoc), .sar_code(sar_code),
        .dn(bus2), .level(level2), .ovf(ovf2), .clr_ovf(clr_ovf), .drop_cnt(drop2)
    );

    always #5 clk = ~clk;

    // Reference state, index 0 = no averaging, index 1 = average of four.
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    int accM[2];
    int cntM[2];
    int ovfM[2];
    int dropM[2];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelStep(input int i, input int avg, input bit r, input bit e,
                             input bit eoc, input logic [7:0] code, input bit rdy,
                             input bit clr);
        logic [7:0] q[$];
        bit         pushNow;
        bit         doPop;
        int         word;
        pushNow = 1'b0;
        word    = 0;
        q = (i == 0) ? q0 : q1;
        if (r) begin
            q.delete();
            accM[i]  = 0;
            cntM[i]  = 0;
            ovfM[i]  = 0;
            dropM[i] = 0;
        end else begin
            doPop = (q.size() > 0) && rdy;
            if (!e) begin
                accM[i] = 0;
                cntM[i] = 0;
            end else if (eoc) begin
                accM[i] += code;
                cntM[i]++;
                if (cntM[i] == (1 << avg)) begin
                    pushNow = 1'b1;
                    word    = accM[i] / (1 << avg);
                    accM[i] = 0;
                    cntM[i] = 0;
                end
            end
            if (clr) begin
                ovfM[i]  = 0;
                dropM[i] = 0;
            end
            if (doPop) void'(q.pop_front());
            if (pushNow) begin
                if (q.size() < DEPTH) q.push_back(8'(word));
                else begin
                    ovfM[i] = 1;
                    if (dropM[i] < 255) dropM[i]++;
                end
            end
        end
        if (i == 0) q0 = q;
        else        q1 = q;
    endtask

    task automatic checkOutput();
        chk("d0_valid", int'(bus0.m_valid), int'(q0.size() > 0));
        chk("d0_level", int'(level0), q0.size());
        chk("d0_ovf", int'(ovf0), ovfM[0]);
        chk("d0_drop", int'(drop0), dropM[0]);
        if (q0.size() > 0) chk("d0_data", int'(bus0.m_data), int'(q0[0]));
        chk("d2_valid", int'(bus2.m_valid), int'(q1.size() > 0));
        chk("d2_level", int'(level2), q1.size());
        chk("d2_ovf", int'(ovf2), ovfM[1]);
        chk("d2_drop", int'(drop2), dropM[1]);
        if (q1.size() > 0) chk("d2_data", int'(bus2.m_data), int'(q1[0]));
    endtask

    // Called at a falling edge; leaves the bench at the next falling edge.
    task automatic applyStimulus(input bit r, input bit e, input bit eoc,
                                 input logic [7:0] code, input bit rdy, input bit clr);
        rst      = r;
        en       = e;
        sar_eoc  = eoc;
        sar_code = code;
        m_ready  = rdy;
        clr_ovf  = clr;
        modelStep(0, 0, r, e, eoc, code, rdy, clr);
        modelStep(1, 2, r, e, eoc, code, rdy, clr);
        @(posedge clk);
        @(negedge clk);
        checkOutput();
    endtask

    task automatic eoc(input logic [7:0] code, input bit rdy);
        applyStimulus(1'b0, 1'b1, 1'b1, code, rdy, 1'b0);
    endtask

    task automatic idle(input bit rdy);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, rdy, 1'b0);
    endtask

    task automatic doReset();
        applyStimulus(1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; sar_eoc = 1'b0; sar_code = '0; m_ready = 1'b0; clr_ovf = 1'b0;
        @(negedge clk);
        doReset();
        doReset();
        chk("rst_valid", int'(bus0.m_valid), 0);
        chk("rst_data", int'(bus0.m_data), 0);
        chk("rst_level", int'(level0), 0);
        chk("rst_ovf", int'(ovf0), 0);
        chk("rst_drop", int'(drop0), 0);

        // Pass-through: each code visible one cycle after its strobe.
        eoc(8'h12, 1'b1);
        chk("t1_a", int'(bus0.m_data), 8'h12);
        idle(1'b1);
        eoc(8'hFE, 1'b1);
        chk("t1_b", int'(bus0.m_data), 8'hFE);
        idle(1'b1);
        eoc(8'h80, 1'b1);
        chk("t1_c", int'(bus0.m_data), 8'h80);
        chk("t1_lvl", int'(level0), 1);
        idle(1'b1);

        // Averaging truncates and the wide accumulator holds four full-scale codes.
        doReset();
        eoc(8'd10, 1'b1);
        eoc(8'd11, 1'b1);
        eoc(8'd12, 1'b1);
        eoc(8'd14, 1'b1);
        chk("t2_avg_valid", int'(bus2.m_valid), 1);
        chk("t2_avg", int'(bus2.m_data), 11);
        idle(1'b1);
        for (int k = 0; k < 4; k++) eoc(8'd255, 1'b1);
        chk("t2_full_scale", int'(bus2.m_data), 255);
        idle(1'b1);

        // Stalled consumer: two of six words are dropped, the first four survive.
        doReset();
        for (int k = 1; k <= 6; k++) eoc(8'(k), 1'b0);
        chk("t3_level", int'(level0), 4);
        chk("t3_ovf", int'(ovf0), 1);
        chk("t3_drop", int'(drop0), 2);
        chk("t3_head", int'(bus0.m_data), 1);
        for (int k = 1; k <= 4; k++) begin
            chk("t3_order", int'(bus0.m_data), k);
            idle(1'b1);
        end
        chk("t3_empty", int'(bus0.m_valid), 0);

        // Full with simultaneous pop and push, then a drop coinciding with a clear.
        doReset();
        for (int k = 0; k < 4; k++) eoc(8'(8'h40 + k), 1'b0);
        eoc(8'h50, 1'b1);
        chk("t4_level", int'(level0), 4);
        chk("t4_noovf", int'(ovf0), 0);
        eoc(8'h51, 1'b0);
        eoc(8'h52, 1'b0);
        chk("t4_drop2", int'(drop0), 2);
        applyStimulus(1'b0, 1'b1, 1'b1, 8'h53, 1'b0, 1'b1);
        chk("t4_clr_ovf", int'(ovf0), 1);
        chk("t4_clr_drop", int'(drop0), 1);
        for (int k = 0; k < 300; k++) eoc(8'(k), 1'b0);
        chk("t4_saturate", int'(drop0), 255);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
        chk("t4_cleared", int'(drop0), 0);

        // Disabling capture discards a partial group.
        doReset();
        eoc(8'd50, 1'b0);
        eoc(8'd60, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'd70, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) eoc(8'd100, 1'b0);
        chk("t5_level", int'(level2), 1);
        chk("t5_avg", int'(bus2.m_data), 100);

        // Reset mid-accumulation with a strobe on the reset edge.
        doReset();
        for (int k = 0; k < 13; k++) eoc(8'(k), 1'b0);
        chk("t6_pre_level", int'(level2), 3);
        applyStimulus(1'b1, 1'b1, 1'b1, 8'd99, 1'b0, 1'b0);
        chk("t6_valid", int'(bus2.m_valid), 0);
        chk("t6_level", int'(level2), 0);
        chk("t6_ovf", int'(ovf0), 0);
        for (int k = 20; k < 24; k++) eoc(8'(k), 1'b0);
        chk("t6_avg", int'(bus2.m_data), 21);

        // Randomized traffic against the model.
        for (int k = 0; k < 3000; k++) begin
            applyStimulus($urandom_range(0, 199) == 0,
                          $urandom_range(0, 7) != 0,
                          $urandom_range(0, 1) == 1,
                          8'($urandom_range(0, 255)),
                          $urandom_range(0, 1) == 1,
                          $urandom_range(0, 31) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
